// File: rtl/bcd_to_score_pkg.sv
// ============================================================================
// Module   : bcd_to_score_pkg
// Purpose  : Shared types and constants for the BCD-to-binary score decoder.
// Contents : state_t (IDLE/CONV), BCD digit constants, decimal multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_to_score_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;
  localparam int         DIGIT_W    = 4;
  localparam int         DEC_MUL    = 10;

endpackage

`default_nettype wire

// File: rtl/bcd_to_score_mac_step.sv
// ============================================================================
// Module   : bcd_mac_step
// Purpose  : One Horner step of decimal-to-binary conversion:
//            o_acc = i_acc * 10 + i_digit, truncated to SCORE_W bits.
// Ports    : i_acc   [SCORE_W] running accumulator
//            i_digit [DIGIT_W] BCD digit to fold in
//            o_acc   [SCORE_W] updated accumulator
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mac_step
  import bcd_to_score_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic [SCORE_W-1:0] i_acc,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [SCORE_W-1:0] o_acc
);

  // x10 is built from two shifts (x8 + x2); the check keeps the shift pair
  // and the decimal base from drifting apart.
  if (DEC_MUL != (1 << 3) + (1 << 1)) begin : g_mul_check
    $error("bcd_mac_step: shift decomposition does not equal DEC_MUL");
  end

  logic [SCORE_W-1:0] w_x10;

  assign w_x10 = (i_acc << 3) + (i_acc << 1);
  assign o_acc = w_x10 + SCORE_W'(i_digit);

endmodule

`default_nettype wire

// File: rtl/bcd_to_score.sv
// ============================================================================
// Module   : bcd_to_score
// Purpose  : Sequential BCD-to-binary decoder. Latches four BCD digits on an
//            accepted start and rebuilds the binary score one digit per clock
//            (thousands first). Invalid digits (>9) are flagged immediately.
// Ports    : clk, reset (sync, active-high)
//            start                      conversion request, sampled in IDLE
//            thousands/hundreds/tens/units_place [4]  BCD digits
//            score [SCORE_W]            result, held between conversions
//            busy                       conversion in progress
//            done                       one-cycle pulse on score/error update
//            error                      last accepted request had a bad digit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_score
  import bcd_to_score_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         thousands_place,
  input  logic [3:0]         hundreds_place,
  input  logic [3:0]         tens_place,
  input  logic [3:0]         units_place,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done,
  output logic               error
);

  // 9999 needs 14 bits; anything narrower would silently wrap.
  if (SCORE_W < 14) begin : g_width_check
    $error("bcd_to_score: SCORE_W must be at least 14");
  end

  // Digit vector, index NUM_DIGITS-1 is the most significant (thousands).
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_in;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_digit, w_digit_nxt;
  logic [1:0]                         r_idx, w_idx_nxt;
  logic [SCORE_W-1:0]                 r_acc, w_acc_nxt;
  logic [SCORE_W-1:0]                 r_score, w_score_nxt;
  logic                               r_busy, w_busy_nxt;
  logic                               r_done, w_done_nxt;
  logic                               r_error, w_error_nxt;
  state_t                             r_state, w_state_nxt;
  logic                               w_any_bad;
  logic [SCORE_W-1:0]                 w_mac_out;

  assign w_in = {thousands_place, hundreds_place, tens_place, units_place};

  always_comb begin
    w_any_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_in[i] > BCD_MAX) w_any_bad = 1'b1;
    end
  end

  bcd_mac_step #(
    .SCORE_W (SCORE_W)
  ) u_mac (
    .i_acc   (r_acc),
    .i_digit (r_digit[r_idx]),
    .o_acc   (w_mac_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_digit <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_score <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
      r_score <= w_score_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_score_nxt = r_score;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_error_nxt = r_error;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_digit_nxt = w_in;
          w_error_nxt = 1'b0;
          if (w_any_bad) begin
            // Rejected request: report at once, leave score untouched.
            w_error_nxt = 1'b1;
            w_done_nxt  = 1'b1;
          end else begin
            w_acc_nxt   = '0;
            w_idx_nxt   = 2'(NUM_DIGITS - 1);
            w_busy_nxt  = 1'b1;
            w_state_nxt = CONV;
          end
        end
      end

      CONV: begin
        w_acc_nxt = w_mac_out;
        if (r_idx == 2'd0) begin
          // Units digit folded in: publish the result.
          w_score_nxt = w_mac_out;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt = r_idx - 2'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign score = r_score;
  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_score.sv
// ============================================================================
// Module   : tb_bcd_to_score
// Purpose  : Self-checking bench for bcd_to_score. Directed cases followed by
//            randomized requests, each checked cycle by cycle against a
//            reference that computes 1000*T + 100*H + 10*U + u directly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_score;

  localparam int SCORE_W = 16;

  logic               clk;
  logic               reset;
  logic               start;
  logic [3:0]         thousands_place;
  logic [3:0]         hundreds_place;
  logic [3:0]         tens_place;
  logic [3:0]         units_place;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;
  logic               error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what score/error should read while the DUT is idle.
  int m_score = 0;
  bit m_error = 1'b0;

  bcd_to_score #(
    .SCORE_W (SCORE_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .thousands_place (thousands_place),
    .hundreds_place  (hundreds_place),
    .tens_place      (tens_place),
    .units_place     (units_place),
    .score           (score),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_score, input bit exp_busy,
                               input bit exp_done, input bit exp_error);
    check_eq({tag, ".score"}, 32'(score), 32'(exp_score));
    check_eq({tag, ".busy"},  32'(busy),  32'(exp_busy));
    check_eq({tag, ".done"},  32'(done),  32'(exp_done));
    check_eq({tag, ".error"}, 32'(error), 32'(exp_error));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request from a negedge and follow it to completion.
  // hold: keep start high throughout (and leave it high on return).
  // scramble: change the input digits while the conversion runs.
  task automatic do_conv(input string tag, input logic [3:0] t, input logic [3:0] h,
                         input logic [3:0] te, input logic [3:0] u,
                         input bit hold, input bit scramble);
    bit bad;
    int exp_val;
    bad     = (t > 4'd9) || (h > 4'd9) || (te > 4'd9) || (u > 4'd9);
    exp_val = 1000 * int'(t) + 100 * int'(h) + 10 * int'(te) + int'(u);
    thousands_place = t;
    hundreds_place  = h;
    tens_place      = te;
    units_place     = u;
    start           = 1'b1;
    step();
    if (bad) begin
      m_error = 1'b1;
      check_outputs({tag, ".inv"}, m_score, 1'b0, 1'b1, 1'b1);
      if (!hold) start = 1'b0;
      return;
    end
    m_error = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_outputs({tag, ".conv"}, m_score, 1'b1, 1'b0, 1'b0);
      start = hold;
      if (scramble) begin
        thousands_place = 4'($urandom_range(0, 15));
        hundreds_place  = 4'($urandom_range(0, 15));
        tens_place      = 4'($urandom_range(0, 15));
        units_place     = 4'($urandom_range(0, 15));
      end
      step();
    end
    m_score = exp_val;
    check_outputs({tag, ".done"}, m_score, 1'b0, 1'b1, 1'b0);
    if (!hold) start = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      check_outputs(tag, m_score, 1'b0, 1'b0, m_error);
    end
  endtask

  function automatic logic [3:0] rand_digit(input bit allow_bad);
    if (allow_bad && ($urandom_range(0, 9) == 0)) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    thousands_place = 4'd0;
    hundreds_place  = 4'd0;
    tens_place      = 4'd0;
    units_place     = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle_cycles("idle0", 2);

    do_conv("d1234", 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
    idle_cycles("after1234", 1);
    do_conv("d00A5", 4'd0, 4'd0, 4'hA, 4'd5, 1'b0, 1'b0);
    idle_cycles("after00A5", 2);
    do_conv("d9999", 4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0);
    idle_cycles("after9999", 1);
    do_conv("d0000", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    idle_cycles("after0000", 2);

    // start held through the whole conversion with shifting inputs.
    do_conv("d5007", 4'd5, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1);
    idle_cycles("after5007", 2);

    // Reset lands on the second CONV edge of an 8888 conversion.
    thousands_place = 4'd8;
    hundreds_place  = 4'd8;
    tens_place      = 4'd8;
    units_place     = 4'd8;
    start           = 1'b1;
    step();
    start = 1'b0;
    check_outputs("d8888.c0", m_score, 1'b1, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    m_score = 0;
    m_error = 1'b0;
    check_outputs("midreset", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle_cycles("postreset", 1);
    do_conv("d0042", 4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0);
    idle_cycles("after0042", 1);

    // Continuous start: back-to-back conversions every 5 cycles.
    for (int r = 0; r < 3; r++) begin
      do_conv("d3141", 4'd3, 4'd1, 4'd4, 4'd1, 1'b1, 1'b0);
    end
    idle_cycles("after3141", 2);

    // Back-to-back invalid requests.
    do_conv("inv_a", 4'hF, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    do_conv("inv_b", 4'd0, 4'd0, 4'd0, 4'hB, 1'b0, 1'b0);
    idle_cycles("afterinv", 1);

    for (int it = 0; it < 40; it++) begin
      do_conv("rand", rand_digit(1'b1), rand_digit(1'b1), rand_digit(1'b1), rand_digit(1'b1),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      idle_cycles("rand_idle", $urandom_range(0, 2));
    end
    idle_cycles("final", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
